// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution post-processing path:
// bias + optional ReLU, requantise/saturate, then 2x2 max-pool.
package conv_pkg;

    localparam int ACC_W = 48;
    localparam int OUT_W = 16;

    localparam logic signed [OUT_W-1:0] OUT_MAX = 16'sh7fff;
    localparam logic signed [OUT_W-1:0] OUT_MIN = 16'sh8000;

    // Saturation bounds widened to the 49-bit biased-sum domain.
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W + 1)'(32767);
    localparam logic signed [ACC_W:0] SUM_MIN = (ACC_W + 1)'(-32768);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic int ofm_size(input int fm, input int k, input int pad, input int stride);
        return (fm - k + 2 * pad) / stride + 1;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] x);
        if (x > SUM_MAX) begin
            return OUT_MAX;
        end else if (x < SUM_MIN) begin
            return OUT_MIN;
        end else begin
            return x[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv_pool_post_if.sv
// Frame-control, conv-result stream and pooled-result signals of conv_pool_post.
interface conv_pool_post_if;
    import conv_pkg::*;

    logic                    i_go;
    logic signed [ACC_W-1:0] i_bias;
    logic                    i_valid;
    logic signed [ACC_W-1:0] i_conv_result;
    logic                    o_valid;
    logic signed [OUT_W-1:0] o_pool_result;
    logic                    o_done;

    modport slave (
        input  i_go, i_bias, i_valid, i_conv_result,
        output o_valid, o_pool_result, o_done
    );

    modport master (
        output i_go, i_bias, i_valid, i_conv_result,
        input  o_valid, o_pool_result, o_done
    );

endinterface

// File: rtl/pool_row_buf.sv
// Row buffer holding the horizontal pair-maxima of the even row of each pooling window.
module pool_row_buf
    import conv_pkg::*;
#(
    parameter  int DEPTH = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_addr,
    input  logic signed [OUT_W-1:0] i_wdata,
    output logic signed [OUT_W-1:0] o_rdata
);

    // Storage is rounded up to a power of two so every address value is in range.
    logic signed [OUT_W-1:0] mem_q [0:(1 << AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/conv_pool_post.sv
// Bias/ReLU, shift-saturate and 2x2 max-pool of a raster conv-result stream.
// Optional feature: define CONV_POOL_RELU_EN to clamp negative biased sums to 0.
module conv_pool_post
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 4,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int SHIFT       = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    conv_pool_post_if.slave io
);

    localparam int OFM_SIZE = ofm_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE);
    localparam int HALF     = OFM_SIZE / 2;
    localparam int CNT_W    = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int AW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OFM_SIZE - 1);

    if ((OFM_SIZE % 2) != 0) begin : g_ofm_odd
        $error("conv_pool_post: OFM_SIZE must be even");
    end

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        row_q, row_d, col_q, col_d;
    logic signed [ACC_W-1:0] bias_q, bias_d;
    logic                    accept;

    logic                    v1_q, v1_d;
    logic signed [ACC_W:0]   sum_q, sum_d;
    logic [CNT_W-1:0]        col1_q, col1_d;
    logic                    row_odd1_q, row_odd1_d;

    logic                    v2_q, v2_d;
    logic signed [OUT_W-1:0] sat_q, sat_d;
    logic [CNT_W-1:0]        col2_q, col2_d;
    logic                    row_odd2_q, row_odd2_d;

    logic signed [OUT_W-1:0] hold_q, hold_d;
    logic                    o_valid_q, o_valid_d;
    logic signed [OUT_W-1:0] o_pool_q, o_pool_d;

    logic                    buf_we;
    logic [AW-1:0]           buf_addr;
    logic signed [OUT_W-1:0] buf_rdata;
    logic signed [OUT_W-1:0] pair;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            bias_q     <= '0;
            v1_q       <= 1'b0;
            sum_q      <= '0;
            col1_q     <= '0;
            row_odd1_q <= 1'b0;
            v2_q       <= 1'b0;
            sat_q      <= '0;
            col2_q     <= '0;
            row_odd2_q <= 1'b0;
            hold_q     <= '0;
            o_valid_q  <= 1'b0;
            o_pool_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            bias_q     <= bias_d;
            v1_q       <= v1_d;
            sum_q      <= sum_d;
            col1_q     <= col1_d;
            row_odd1_q <= row_odd1_d;
            v2_q       <= v2_d;
            sat_q      <= sat_d;
            col2_q     <= col2_d;
            row_odd2_q <= row_odd2_d;
            hold_q     <= hold_d;
            o_valid_q  <= o_valid_d;
            o_pool_q   <= o_pool_d;
        end
    end

    // Frame control: inputs are only counted in RUN; FLUSH drains the three-stage pipe.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        bias_d  = bias_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.i_go) begin
                    bias_d  = io.i_bias;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (io.i_valid) begin
                    accept = 1'b1;
                    if (col_q == LAST) begin
                        col_d = '0;
                        if (row_q == LAST) begin
                            row_d   = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            row_d = row_q + CNT_W'(1);
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (!v1_q && !v2_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath; ties in either max keep the earlier (left, then upper) value.
    always_comb begin
        v1_d       = accept;
        sum_d      = (ACC_W + 1)'(io.i_conv_result) + (ACC_W + 1)'(bias_q);
`ifdef CONV_POOL_RELU_EN
        if (sum_d[ACC_W]) begin
            sum_d = '0;
        end
`else
`endif
        col1_d     = col_q;
        row_odd1_d = row_q[0];

        v2_d       = v1_q;
        sat_d      = saturate(sum_q >>> SHIFT);
        col2_d     = col1_q;
        row_odd2_d = row_odd1_q;

        pair     = (sat_q > hold_q) ? sat_q : hold_q;
        buf_addr = AW'(col2_q >> 1);
        buf_we   = v2_q && col2_q[0] && !row_odd2_q;
        hold_d   = hold_q;
        if (v2_q && !col2_q[0]) begin
            hold_d = sat_q;
        end
        o_valid_d = v2_q && col2_q[0] && row_odd2_q;
        o_pool_d  = o_pool_q;
        if (o_valid_d) begin
            o_pool_d = (pair > buf_rdata) ? pair : buf_rdata;
        end
    end

    pool_row_buf #(
        .DEPTH (HALF)
    ) u_row_buf (
        .i_clk   (i_clk),
        .i_we    (buf_we),
        .i_addr  (buf_addr),
        .i_wdata (pair),
        .o_rdata (buf_rdata)
    );

    assign io.o_valid       = o_valid_q;
    assign io.o_pool_result = o_pool_q;
    assign io.o_done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_pool_post.sv
// Scoreboard bench for conv_pool_post: three instances (defaults, SHIFT=4, FM_SIZE=6).
module tb_conv_pool_post;
    import conv_pkg::*;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   pend[3];
    int   last_v[3];

    logic signed [ACC_W-1:0] stim[16];
    int                      expv[4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv_pool_post_if if0 ();
    conv_pool_post_if if1 ();
    conv_pool_post_if if2 ();

    conv_pool_post #(.SHIFT(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .io(if0));
    conv_pool_post #(.SHIFT(4)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .io(if1));
    conv_pool_post #(.FM_SIZE(6)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .io(if2));

    task automatic cmp(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic drive(input int which, input logic go, input logic valid,
                         input logic signed [ACC_W-1:0] data, input logic signed [ACC_W-1:0] bias);
        case (which)
            0: begin if0.i_go = go; if0.i_valid = valid; if0.i_conv_result = data; if0.i_bias = bias; end
            1: begin if1.i_go = go; if1.i_valid = valid; if1.i_conv_result = data; if1.i_bias = bias; end
            default: begin if2.i_go = go; if2.i_valid = valid; if2.i_conv_result = data; if2.i_bias = bias; end
        endcase
    endtask

    task automatic push(input int which, input int val, input int cy);
        exp_t e;
        e.val = val;
        e.cyc = cy;
        case (which)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic set4(input int a, input int b, input int c, input int d, input int e0);
        stim[0] = ACC_W'(a);
        stim[1] = ACC_W'(b);
        stim[2] = ACC_W'(c);
        stim[3] = ACC_W'(d);
        expv[0] = e0;
    endtask

    // Monitor side: pops the scoreboard whenever a DUT presents a result or o_done.
    task automatic checkOutput(input int which, input logic v, input logic signed [OUT_W-1:0] r, input logic d);
        exp_t e;
        int   n;
        n = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
        if (v === 1'b1) begin
            if (n == 0) begin
                cmp($sformatf("dut%0d unexpected o_valid", which), 1, 0);
            end else begin
                case (which)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                cmp($sformatf("dut%0d pool value", which), longint'(r), longint'(e.val));
                cmp($sformatf("dut%0d o_valid cycle", which), longint'(cyc), longint'(e.cyc));
                last_v[which] = cyc;
            end
        end
        if (d === 1'b1) begin
            cmp($sformatf("dut%0d o_done expected", which), longint'(pend[which] > 0), 1);
            cmp($sformatf("dut%0d o_done after last o_valid", which), longint'(cyc - last_v[which]), 1);
            if (pend[which] > 0) pend[which]--;
        end
    endtask

    always @(negedge clk) checkOutput(0, if0.o_valid, if0.o_pool_result, if0.o_done);
    always @(negedge clk) checkOutput(1, if1.o_valid, if1.o_pool_result, if1.o_done);
    always @(negedge clk) checkOutput(2, if2.o_valid, if2.o_pool_result, if2.o_done);

    task automatic checkResetState();
        cmp("dut0 reset o_valid", longint'(if0.o_valid), 0);
        cmp("dut0 reset o_done", longint'(if0.o_done), 0);
        cmp("dut0 reset o_pool_result", longint'(if0.o_pool_result), 0);
        cmp("dut1 reset o_valid", longint'(if1.o_valid), 0);
        cmp("dut1 reset o_done", longint'(if1.o_done), 0);
        cmp("dut1 reset o_pool_result", longint'(if1.o_pool_result), 0);
        cmp("dut2 reset o_valid", longint'(if2.o_valid), 0);
        cmp("dut2 reset o_done", longint'(if2.o_done), 0);
        cmp("dut2 reset o_pool_result", longint'(if2.o_pool_result), 0);
    endtask

    task automatic waitDone(input int which);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (pend[which] == 0);
        end
        cmp($sformatf("dut%0d frame completes", which), longint'(ok), 1);
        @(negedge clk);
    endtask

    // One frame: go pulse, n back-to-back inputs; expectations pushed at each window's bottom-right.
    // mid >= 0 also pulses i_go (with a different bias) alongside input number mid.
    task automatic applyStimulus(input int which, input int bias, input int n, input int mid);
        int ofm = (which == 2) ? 4 : 2;
        int k   = 0;
        pend[which]++;
        @(negedge clk);
        drive(which, 1'b1, 1'b0, '0, ACC_W'(bias));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(which, (i == mid), 1'b1, stim[i], (i == mid) ? ACC_W'(1000) : ACC_W'(bias));
            if (((i / ofm) % 2 == 1) && ((i % ofm) % 2 == 1)) begin
                push(which, expv[k], cyc + 3);
                k++;
            end
        end
        @(negedge clk);
        drive(which, 1'b0, 1'b0, '0, ACC_W'(bias));
        waitDone(which);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) begin
            drive(w, 1'b0, 1'b0, '0, '0);
            pend[w]   = 0;
            last_v[w] = 0;
        end
        repeat (3) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic window and bias/ReLU");
        set4(5, -3, 7, 2, 7);
        applyStimulus(0, 0, 4, -1);
`ifdef CONV_POOL_RELU_EN
        set4(-1, -2, -3, -4, 0);
`else
        set4(-1, -2, -3, -4, -11);
`endif
        applyStimulus(0, -10, 4, -1);

        $display("[TB] saturation and shift");
        set4(100000, 1, 2, 3, 32767);
        applyStimulus(0, 0, 4, -1);
`ifdef CONV_POOL_RELU_EN
        set4(-100000, -100000, -100000, -100000, 0);
`else
        set4(-100000, -100000, -100000, -100000, -32768);
`endif
        applyStimulus(0, 0, 4, -1);
        set4(160, 0, 0, 0, 10);
        applyStimulus(1, 0, 4, -1);

        $display("[TB] 4x4 output map");
        for (int i = 0; i < 16; i++) stim[i] = ACC_W'(i);
        expv[0] = 5;
        expv[1] = 7;
        expv[2] = 13;
        expv[3] = 15;
        applyStimulus(2, 0, 16, -1);

        $display("[TB] stray i_valid in IDLE and i_go in RUN");
        @(negedge clk);
        drive(0, 1'b0, 1'b1, ACC_W'(30000), '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        set4(1, 2, 3, 4, 4);
        applyStimulus(0, 0, 4, 1);

        $display("[TB] reset mid-frame");
        @(negedge clk);
        drive(0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, ACC_W'(20000), '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, ACC_W'(20001), '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        set4(9, 8, 7, 6, 9);
        applyStimulus(0, 0, 4, -1);

        repeat (5) @(negedge clk);
        cmp("dut0 outputs outstanding", longint'(q0.size()), 0);
        cmp("dut1 outputs outstanding", longint'(q1.size()), 0);
        cmp("dut2 outputs outstanding", longint'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/conv_pool_post.md
CONV_POOL_POST -- requirements
Module: conv_pool_post

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, convolution kernel side.
REQ-002 SHALL have parameter FM_SIZE, default 4, input feature-map side.
REQ-003 SHALL have parameter PADDING, default 0, convolution padding.
REQ-004 SHALL have parameter STRIDE, default 1, convolution stride.
REQ-005 SHALL have parameter SHIFT, default 0, requantisation right-shift amount.
REQ-006 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-007 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_go  input  1  frame start pulse.
REQ-009 SHALL have port i_bias  input  48 signed  bias, sampled on accepted i_go.
REQ-010 SHALL have port i_valid  input  1  conv result valid (from conv_blk).
REQ-011 SHALL have port i_conv_result  input  48 signed  conv result, raster order.
REQ-012 SHALL have port o_valid  output  1  pooled result valid, one-cycle pulse.
REQ-013 SHALL have port o_pool_result  output  16 signed  2x2 max-pooled value.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse after the last pooled output.

Function
REQ-015 SHALL derive OFM_SIZE = (FM_SIZE - KERNEL_SIZE + 2*PADDING)/STRIDE + 1; OFM_SIZE SHALL be even, otherwise elaboration fails.
REQ-016 SHALL implement FSM IDLE -> RUN on i_go; RUN -> FLUSH after OFM_SIZE*OFM_SIZE accepted inputs; FLUSH -> DONE when the pipeline is empty; DONE -> IDLE after one cycle, with o_done=1 in DONE.
REQ-017 SHALL latch i_bias and clear row/column counters on i_go in IDLE; i_go SHALL be ignored in RUN, FLUSH and DONE.
REQ-018 SHALL accept i_valid only in RUN; i_valid in other states SHALL be dropped. No backpressure is provided.
REQ-019 Stage 1: sum = i_conv_result + bias (49-bit); ReLU clamps negative sums to 0 (see REQ-028).
REQ-020 Stage 2: arithmetic shift right by SHIFT, then saturate to [-32768, 32767].
REQ-021 Stage 3, pooling at even column: hold value. At odd column: pair = max(hold, current).
REQ-022 On even rows, pair SHALL be written to row buffer[col/2], OFM_SIZE/2 entries x 16 bits.
REQ-023 On odd rows, o_pool_result = max(pair, buffer[col/2]) and o_valid=1.
REQ-024 o_valid SHALL assert exactly 3 cycles after the i_valid of the bottom-right element of each window.
REQ-025 Outputs SHALL be emitted in raster order, (OFM_SIZE/2)^2 per frame.
REQ-026 The last o_valid and o_done SHALL NOT share a cycle; o_done SHALL follow the last o_valid by exactly 1 cycle.
REQ-027 Signed comparison SHALL be used throughout; ties keep the earlier value.

Configuration
REQ-028 Macro CONV_POOL_RELU_EN. When defined, stage 1 clamps negative sums to 0. When undefined, negative values pass through to saturation and pooling unchanged.

Reset
REQ-029 While i_rst_n=0, the block SHALL be in state IDLE with o_valid=0, o_done=0, o_pool_result=0, counters=0, bias=0, and pipeline valid bits=0; buffer contents are don't-care.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_valid and no o_done; the first i_go after release starts a fresh frame.

Structure
REQ-031 A shared package conv_pkg SHALL hold ACC_W=48, OUT_W=16, the OUT_MAX/OUT_MIN constants, the FSM state typedef, and the OFM_SIZE function.
REQ-032 A single sub-module, pool_row_buf (synchronous-write, combinational-read buffer of OFM_SIZE/2 x OUT_W), is natural.

Verification
REQ-033 Defaults, bias=0, inputs 5,-3,7,2 -> a single o_valid with value 7, then o_done one cycle later.
REQ-034 Bias=-10, inputs -1,-2,-3,-4 -> 0 with CONV_POOL_RELU_EN defined; -11 without it.
REQ-035 Input 100000 with SHIFT=0 -> 32767; input 160 with SHIFT=4 (others 0) -> 10.
REQ-036 FM_SIZE=6, inputs 0..15 in raster order -> outputs 5,7,13,15 in order, then o_done.
REQ-037 i_go pulsed mid-RUN, and i_valid pulsed in IDLE -> no effect on outputs or counts.
REQ-038 i_rst_n low after 2 inputs -> no o_valid/o_done; a new frame after release yields the correct result.
